// File: rtl/wino_pkg.sv
// Shared Winograd definitions: tile size types, strides, index widths and the
// scheduler state encoding used by the PE, transform and sequencing blocks.
package wino_pkg;

    typedef enum logic {
        SZ_1X1_T6 = 1'b0,
        SZ_3X3_T4 = 1'b1
    } size_type_e;

    localparam logic [3:0] STRIDE_T6 = 4'd6;
    localparam logic [3:0] STRIDE_T4 = 4'd4;

    localparam int X_W  = 9;
    localparam int OD_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    function automatic logic [3:0] stride_of(input size_type_e sz);
        return (sz == SZ_3X3_T4) ? STRIDE_T4 : STRIDE_T6;
    endfunction

endpackage

// File: rtl/wino_inflight_ctr.sv
// Up/down credit counter for data tiles awaiting a PE result; reports whether
// another tile may be issued next cycle and flags results with nothing in flight.
module wino_inflight_ctr #(
    parameter int MAX_INFLIGHT = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_room_next,
    output logic o_empty_next,
    output logic o_underflow
);

    logic [3:0] r_count;
    logic [3:0] w_count_next;

    always_comb begin
        w_count_next = r_count;
        if (i_inc && !i_dec) begin
            w_count_next = r_count + 4'd1;
        end else if (i_dec && !i_inc && (r_count != 4'd0)) begin
            w_count_next = r_count - 4'd1;
        end
    end

    assign o_underflow  = i_dec && (r_count == 4'd0);
    assign o_room_next  = (w_count_next < 4'(MAX_INFLIGHT));
    assign o_empty_next = (w_count_next == 4'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 4'd0;
        end else begin
            r_count <= w_count_next;
        end
    end

endmodule

// File: rtl/wino_tile_scheduler.sv
// Layer sequencer for the Winograd PE array: per output channel one weight load,
// then one data-tile request per spatial tile, throttled by results in flight.
module wino_tile_scheduler
    import wino_pkg::*;
#(
    parameter int MAX_INFLIGHT = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start_i,
    input  logic [X_W-1:0]  cfg_height_i,
    input  logic [X_W-1:0]  cfg_width_i,
    input  logic [OD_W-1:0] cfg_od_i,
    input  logic            cfg_size_type_i,
    output logic            weight_valid_o,
    input  logic            weight_ready_i,
    output logic [OD_W-1:0] weight_od_o,
    output logic            weight_size_type_o,
    output logic            data_valid_o,
    input  logic            data_ready_i,
    output logic [X_W-1:0]  data_x_index_o,
    output logic [X_W-1:0]  data_y_index_o,
    input  logic            result_valid_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);

    state_e          r_state;
    logic [X_W-1:0]  r_h, r_w, r_x, r_y;
    logic [OD_W-1:0] r_odn, r_od;
    size_type_e      r_sz;
    logic            r_wvld, r_dvld, r_busy, r_done, r_err;

    logic            w_data_hs, w_zero_cfg;
    logic            w_room_next, w_empty_next, w_underflow;
    logic [X_W:0]    w_stride, w_y_next, w_x_next;
    logic [OD_W:0]   w_od_next;

    assign w_data_hs  = r_dvld && data_ready_i;
    assign w_zero_cfg = (cfg_height_i == '0) || (cfg_width_i == '0) || (cfg_od_i == '0);
    assign w_stride   = {{(X_W - 3){1'b0}}, stride_of(r_sz)};
    assign w_y_next   = {1'b0, r_y} + w_stride;
    assign w_x_next   = {1'b0, r_x} + w_stride;
    assign w_od_next  = {1'b0, r_od} + {{OD_W{1'b0}}, 1'b1};

    wino_inflight_ctr #(
        .MAX_INFLIGHT(MAX_INFLIGHT)
    ) u_inflight (
        .i_clk        (clk),
        .i_rst_n      (reset_n),
        .i_inc        (w_data_hs),
        .i_dec        (result_valid_i),
        .o_room_next  (w_room_next),
        .o_empty_next (w_empty_next),
        .o_underflow  (w_underflow)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_h     <= '0;
            r_w     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_odn   <= '0;
            r_od    <= '0;
            r_sz    <= SZ_1X1_T6;
            r_wvld  <= 1'b0;
            r_dvld  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_underflow) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_h    <= cfg_height_i;
                        r_w    <= cfg_width_i;
                        r_odn  <= cfg_od_i;
                        r_sz   <= size_type_e'(cfg_size_type_i);
                        r_err  <= 1'b0;
                        r_od   <= '0;
                        r_x    <= '0;
                        r_y    <= '0;
                        r_busy <= 1'b1;
                        // An empty layer has nothing in flight, so draining completes it.
                        if (w_zero_cfg) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_wvld  <= 1'b1;
                            r_state <= ST_LOAD_W;
                        end
                    end
                end
                ST_LOAD_W: begin
                    if (weight_ready_i) begin
                        r_wvld  <= 1'b0;
                        r_dvld  <= w_room_next;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_data_hs) begin
                        if (w_y_next < {1'b0, r_w}) begin
                            r_y    <= w_y_next[X_W-1:0];
                            r_dvld <= w_room_next;
                        end else if (w_x_next < {1'b0, r_h}) begin
                            r_y    <= '0;
                            r_x    <= w_x_next[X_W-1:0];
                            r_dvld <= w_room_next;
                        end else begin
                            r_y    <= '0;
                            r_x    <= '0;
                            r_od   <= w_od_next[OD_W-1:0];
                            r_dvld <= 1'b0;
                            if (w_od_next == {1'b0, r_odn}) begin
                                r_state <= ST_DRAIN;
                            end else begin
                                r_wvld  <= 1'b1;
                                r_state <= ST_LOAD_W;
                            end
                        end
                    end else if (!r_dvld) begin
                        // A pending request is never withdrawn; only a fresh one waits for credit.
                        r_dvld <= w_room_next;
                    end
                end
                ST_DRAIN: begin
                    if (w_empty_next) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign weight_valid_o     = r_wvld;
    assign weight_od_o        = r_od;
    assign weight_size_type_o = r_sz;
    assign data_valid_o       = r_dvld;
    assign data_x_index_o     = r_x;
    assign data_y_index_o     = r_y;
    assign busy_o             = r_busy;
    assign done_o             = r_done;
    assign err_o              = r_err;

endmodule

// File: tb/tb_wino_tile_scheduler.sv
// Scoreboard bench for wino_tile_scheduler: a loop-nest model predicts the
// handshake stream, a negedge monitor compares it and answers tiles with results.
module tb_wino_tile_scheduler;

    localparam int MAXF = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_i = 1'b0;
    logic [8:0] cfg_height_i = '0;
    logic [8:0] cfg_width_i = '0;
    logic [7:0] cfg_od_i = '0;
    logic       cfg_size_type_i = 1'b0;
    logic       weight_valid_o;
    logic       weight_ready_i = 1'b1;
    logic [7:0] weight_od_o;
    logic       weight_size_type_o;
    logic       data_valid_o;
    logic       data_ready_i = 1'b1;
    logic [8:0] data_x_index_o;
    logic [8:0] data_y_index_o;
    logic       result_valid_i = 1'b0;
    logic       busy_o, done_o, err_o;

    always #5 clk = ~clk;

    wino_tile_scheduler #(.MAX_INFLIGHT(MAXF)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start_i           (start_i),
        .cfg_height_i      (cfg_height_i),
        .cfg_width_i       (cfg_width_i),
        .cfg_od_i          (cfg_od_i),
        .cfg_size_type_i   (cfg_size_type_i),
        .weight_valid_o    (weight_valid_o),
        .weight_ready_i    (weight_ready_i),
        .weight_od_o       (weight_od_o),
        .weight_size_type_o(weight_size_type_o),
        .data_valid_o      (data_valid_o),
        .data_ready_i      (data_ready_i),
        .data_x_index_o    (data_x_index_o),
        .data_y_index_o    (data_y_index_o),
        .result_valid_i    (result_valid_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .err_o             (err_o)
    );

    typedef struct {
        bit is_w;
        int od;
        int x;
        int y;
        int sz;
    } ev_t;

    ev_t exp_q[$];
    int  due_q[$];
    ev_t e;
    int  checks = 0, errors = 0;
    int  cyc = 0;
    bit  stall_en = 0, hold = 0, r = 0;
    int  rel_req = 0, rel_used = 0, man_req = 0, man_used = 0;
    int  n_whs = 0, n_dhs = 0, n_valid = 0, done_cnt = 0, done_cyc = 0, last_res_cyc = 0;
    bit  pw_pend = 0, pd_pend = 0;
    int  pw_od = 0, pd_x = 0, pd_y = 0;
    int  b_done, b_w, b_d, e_w, e_d;

    task automatic chk(input string nm, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (stall_en) begin
            weight_ready_i = 1'($urandom_range(0, 1));
            data_ready_i   = 1'($urandom_range(0, 1));
        end else begin
            weight_ready_i = 1'b1;
            data_ready_i   = 1'b1;
        end
    end

    // Monitor, scoreboard and PE result responder.
    always @(negedge clk) begin
        if (!reset_n) begin
            pw_pend = 0;
            pd_pend = 0;
            due_q.delete();
            result_valid_i = 1'b0;
        end else begin
            if (pw_pend) begin
                chk("w_hold_valid", weight_valid_o, 1);
                chk("w_hold_od", weight_od_o, pw_od);
            end
            if (pd_pend) begin
                chk("d_hold_valid", data_valid_o, 1);
                chk("d_hold_x", data_x_index_o, pd_x);
                chk("d_hold_y", data_y_index_o, pd_y);
            end
            if (weight_valid_o || data_valid_o) n_valid++;
            if (weight_valid_o && weight_ready_i) begin
                n_whs++;
                chk("w_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("w_kind", 1, e.is_w);
                    chk("w_od", weight_od_o, e.od);
                    chk("w_sz", weight_size_type_o, e.sz);
                end
            end
            if (data_valid_o && data_ready_i) begin
                n_dhs++;
                due_q.push_back(cyc + 3);
                chk("d_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("d_kind", 0, e.is_w);
                    chk("d_x", data_x_index_o, e.x);
                    chk("d_y", data_y_index_o, e.y);
                end
            end
            pw_pend = weight_valid_o && !weight_ready_i;
            pw_od   = weight_od_o;
            pd_pend = data_valid_o && !data_ready_i;
            pd_x    = data_x_index_o;
            pd_y    = data_y_index_o;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_q_empty", exp_q.size(), 0);
            end
            r = 0;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                if (!hold) begin
                    r = 1;
                    void'(due_q.pop_front());
                end else if (rel_used < rel_req) begin
                    r = 1;
                    rel_used++;
                    void'(due_q.pop_front());
                end
            end
            if (man_used < man_req) begin
                r = 1;
                man_used++;
            end
            if (r) last_res_cyc = cyc;
            result_valid_i = r;
        end
    end

    task automatic build_exp(input int h, input int w, input int od, input int sz);
        int s;
        s = (sz != 0) ? 4 : 6;
        e_w = 0;
        e_d = 0;
        for (int o = 0; o < od; o++) begin
            exp_q.push_back('{1'b1, o, 0, 0, sz});
            e_w++;
            for (int x = 0; x < h; x += s)
                for (int y = 0; y < w; y += s) begin
                    exp_q.push_back('{1'b0, 0, x, y, 0});
                    e_d++;
                end
        end
    endtask

    task automatic start_layer(input int h, input int w, input int od, input int sz);
        b_done = done_cnt;
        b_w    = n_whs;
        b_d    = n_dhs;
        build_exp(h, w, od, sz);
        @(negedge clk);
        cfg_height_i    = 9'(h);
        cfg_width_i     = 9'(w);
        cfg_od_i        = 8'(od);
        cfg_size_type_i = 1'(sz);
        start_i         = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    task automatic finish_layer(input bit chk_timing);
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done_cnt != b_done) break;
        end
        chk("done_seen", done_cnt - b_done, 1);
        chk("w_hs_count", n_whs - b_w, e_w);
        chk("d_hs_count", n_dhs - b_d, e_d);
        chk("results_drained", due_q.size(), 0);
        chk("err_clean", err_o, 0);
        if (chk_timing) chk("done_latency", done_cyc - last_res_cyc, 1);
        @(posedge clk);
        #1 chk("busy_low", busy_o, 0);
    endtask

    task automatic run_layer(input int h, input int w, input int od, input int sz, input bit tim);
        start_layer(h, w, od, sz);
        chk("start_busy", busy_o, 1);
        chk("start_wvld", weight_valid_o, 1);
        chk("start_err_clr", err_o, 0);
        finish_layer(tim);
    endtask

    initial begin
        int bv;
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", {weight_valid_o, weight_od_o, weight_size_type_o, data_valid_o,
                                 data_x_index_o, data_y_index_o, busy_o, done_o, err_o}, 0);
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_layer(8, 8, 2, 1, 1);
        run_layer(7, 6, 1, 0, 1);

        stall_en = 1;
        for (int k = 0; k < 4; k++)
            run_layer($urandom_range(1, 30), $urandom_range(1, 30), $urandom_range(1, 3),
                      $urandom_range(0, 1), 0);
        run_layer(8, 8, 2, 1, 0);
        stall_en = 0;
        repeat (2) @(negedge clk);

        hold = 1;
        start_layer(40, 40, 1, 1);
        repeat (20) @(negedge clk);
        chk("limit_hs", n_dhs - b_d, MAXF);
        chk("limit_dvld_low", data_valid_o, 0);
        rel_req++;
        repeat (10) @(negedge clk);
        chk("limit_one_more", n_dhs - b_d, MAXF + 1);
        chk("limit_dvld_low2", data_valid_o, 0);
        hold = 0;
        finish_layer(0);

        bv = n_valid;
        start_layer(8, 8, 0, 1);
        chk("zero_busy", busy_o, 1);
        chk("zero_wvld", weight_valid_o, 0);
        @(posedge clk);
        #1 chk("zero_done_pulse", done_o, 1);
        @(posedge clk);
        #1 chk("zero_done_end", done_o, 0);
        chk("zero_busy_low", busy_o, 0);
        chk("zero_no_valid", n_valid - bv, 0);
        man_req++;
        repeat (3) @(negedge clk);
        chk("idle_result_err", err_o, 1);
        run_layer(8, 8, 1, 0, 0);

        start_layer(40, 40, 2, 1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (n_dhs - b_d >= 5) break;
        end
        chk("abort_progress", n_dhs - b_d >= 5, 1);
        #2 reset_n = 1'b0;
        #1 chk("abort_outputs", {weight_valid_o, weight_od_o, weight_size_type_o, data_valid_o,
                                 data_x_index_o, data_y_index_o, busy_o, done_o, err_o}, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_done", done_cnt - b_done, 0);
        run_layer(8, 8, 2, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wino_tile_scheduler.md
# wino_tile_scheduler

Sequencer for the Winograd PE array. On a start pulse it walks every (output channel, tile row, tile column) of one layer. For each output channel it issues one weight-load handshake toward the weight-transform path, then one data-tile handshake per spatial tile toward the input-transform path. It tracks tiles in flight against PE result pulses, limits outstanding work, and signals completion once every issued tile has produced a result.

## Interface
Parameters:
- MAX_INFLIGHT, 8: maximum data tiles issued but not yet answered by result_valid_i (1..15).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start_i  in  1  one-cycle pulse; ignored unless in IDLE
- cfg_height_i  in  9  input height H; latched on accepted start
- cfg_width_i  in  9  input width W; latched on accepted start
- cfg_od_i  in  8  output-channel count OD; latched on accepted start
- cfg_size_type_i  in  1  0 = 1x1 kernel, 6x6 tile, stride 6; 1 = 3x3 kernel, 4x4 tile, stride 4
- weight_valid_o  out  1  weight-load request
- weight_ready_i  in  1  weight path accepts
- weight_od_o  out  8  output channel to load
- weight_size_type_o  out  1  latched size type
- data_valid_o  out  1  data-tile request
- data_ready_i  in  1  input path accepts
- data_x_index_o  out  9  first row index of tile
- data_y_index_o  out  9  first column index of tile
- result_valid_i  in  1  one pulse per completed PE result tile
- busy_o  out  1  high from accepted start until done_o
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky: result_valid_i received with zero tiles in flight; cleared on accepted start

## Operation
- Reset clears all outputs and registers to 0, state = IDLE.
- Stride S = 6 if size_type = 0, otherwise 4. Tile origins: x = 0, S, 2S, ... while x < H; y = 0, S, ... while y < W. Loop order: od outer, x middle, y inner.
- IDLE: on start_i, latch cfg, clear err_o, set od = x = y = 0.
  - If any of H, W, OD is 0, go to DONE.
  - Otherwise go to LOAD_W.
- LOAD_W: weight_valid_o = 1 with weight_od_o = od. On weight_ready_i, go to ISSUE.
- ISSUE: data_valid_o = 1 whenever inflight < MAX_INFLIGHT. On a data handshake:
  - Compute y' = y + S in 10 bits. If y' < W, then y = y'.
  - Else y = 0 and x' = x + S; if x' < H, then x = x'.
  - Else x = 0 and od = od + 1. If the new od equals OD, go to DRAIN; otherwise go to LOAD_W.
- DRAIN: wait until inflight = 0, then go to DONE.
- DONE: pulse done_o, go to IDLE.
- Inflight counter, 4 bits:
  - +1 on data handshake; −1 on result_valid_i; simultaneous = unchanged.
  - result_valid_i at inflight = 0: counter holds and err_o is set.
- Valid/ready rules: once valid is high, it and its payload stay stable until ready. data_valid_o does not drop for inflight reasons while a request is pending; the inflight check gates only a new assertion.
- Reset mid-operation aborts immediately to IDLE; no done_o is produced.

## Timing
- All outputs are registered.
- Accepted start at edge N: busy_o = 1 and weight_valid_o = 1 from N+1.
- Weight handshake at edge M: data_valid_o rises at M+1.
- Back-to-back data handshakes are allowed, one per cycle.
- Last result pulse at edge R with state DRAIN: done_o at R+1, busy_o low at R+2.
- Zero-size config: done_o at N+2; no valid is ever asserted.

## Structure
- Shared package wino_pkg holds:
  - size-type enum (SZ_1X1_T6 = 0, SZ_3X3_T4 = 1)
  - stride constants 6/4
  - index widths (X 9, OD 8)
  - state enum.
- The PE and transform blocks use the same package.
- One natural sub-module: wino_inflight_ctr (up/down credit counter with limit compare and underflow error).

## Test plan
- H = 8, W = 8, OD = 2, type 1, ready tied high, result pulses 3 cycles after each issue:
  - weight od 0, then data (0,0),(0,4),(4,0),(4,4); weight od 1, then same four tiles.
  - done_o after the 8th result; err_o = 0.
- H = 7, W = 6, type 0, OD = 1 → data (0,0),(6,0) only; done after 2 results.
- Random ready stalls on both paths → payload stable while valid && !ready; handshake sequence identical to the no-stall run.
- MAX_INFLIGHT = 4, results withheld → exactly 4 data handshakes, then data_valid_o low. One result pulse → exactly one more handshake.
- OD = 0 → done_o at N+2, no valids. Then result_valid_i in IDLE → err_o = 1, cleared by the next start.
- reset_n low mid-ISSUE → all outputs 0 at once; a new start replays from (od 0, 0, 0).
